stepper_seq_ctrl: RTL and testbench
===================================

// Module: stepper_seq_ctrl
// PURPOSE
//  Multi-channel unipolar stepper sequencer replacing the fixed single-speed
//  move/cut coil drivers. Each channel accepts a (steps, dir, period) command,
//  emits the 4-bit coil pattern on GPIO, and reports busy/done to the control FSM.
//  It is shared by the mover and cutter motors under one global pause.
// PARAMETERS
//  NUM_CH     2       number of independent motor channels
//  TICK_DIV   50000   clk cycles per step-timing tick (1 kHz at 50 MHz); must be >=2
//  PER_W      8       width of per-channel period (ticks per step)
//  STEP_W     16      width of step count
//  IDLE_HOLD  0       1: coils keep last pattern in IDLE; 0: coils = 4'b0000 in IDLE
// PORTS
//  clk          in   1             system clock (CLOCK_50)
//  rst          in   1             asynchronous reset, active-high
//  pause_i      in   1             level; freezes all RUN channels
//  abort_i      in   NUM_CH        per-channel level; cancels the active command
//  cmd_valid_i  in   NUM_CH        command request
//  cmd_ready_o  out  NUM_CH        channel can accept a command
//  cmd_steps_i  in   NUM_CH*STEP_W steps to move; ch k at [k*STEP_W +: STEP_W]
//  cmd_dir_i    in   NUM_CH        1 = phase index increments; 0 = decrements
//  cmd_period_i in   NUM_CH*PER_W  ticks per step; 0 is treated as 1
//  coil_o       out  NUM_CH*4      coil pattern; ch k at [k*4 +: 4]
//  busy_o       out  NUM_CH        channel in RUN or PAUSED
//  done_o       out  NUM_CH        1-cycle pulse: command completed (not on abort)
// BEHAVIOUR
//  - Reset: coil_o=0, busy_o=0, done_o=0, cmd_ready_o=all 1, phase index=0,
//    prescaler=0. Reset applied mid-move returns all channels to IDLE immediately.
//  - Prescaler: a shared counter wraps at TICK_DIV-1. tick is high for one clk on the wrap.
//  - Per-channel FSM: IDLE -> RUN -> PAUSED -> IDLE.
//    IDLE: cmd_ready=~abort. Accept on valid&ready. Latch steps, dir, and max(period,1).
//          Clear the period counter. Next cycle: busy=1 and coil_o = pattern(phase).
//          If steps==0, go to IDLE the next cycle with done=1, no phase change, and no busy.
//    RUN: on each tick, period counter++. When it reaches the period, the phase
//         advances by +/-1 modulo NPH, remaining is decremented, and the counter
//         is cleared. When remaining reaches 0 on that step, go to IDLE with done=1
//         in the same cycle. N steps take exactly N*period ticks after acceptance.
//    pause_i=1: RUN->PAUSED. The counter and remaining are frozen, and coils hold the
//         current pattern. pause_i=0 returns to RUN, and counting resumes from the frozen value.
//    abort_i=1 in RUN/PAUSED: go to IDLE the next cycle. No done, the phase is kept,
//         and remaining is discarded. Priority: abort > pause > tick step.
//  - Phase index wraps: NPH-1 -> 0 when dir=1, and 0 -> NPH-1 when dir=0.
//  - Full-step table (NPH=4, idx 0..3): 1100, 0110, 0011, 1001.
//  - IDLE coils: the last pattern if IDLE_HOLD=1, else 0000.
//  - The phase index persists across commands, so there is no position jump on re-start.
//  - Channels are fully independent. Only the tick and pause_i are shared.
// CONFIGURATION
//  - STEPPER_HALF_STEP_EN defined: NPH=8 with the half-step table (idx 0..7):
//    1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. Each commanded step is one
//    half-step.
//  - Undefined: NPH=4 with the full-step table above. The phase index is 2 bits,
//    otherwise 3 bits.
// STRUCTURE
//  - stepper_pkg: ch_state_e {IDLE, RUN, PAUSED}, NPH localparam (macro-dependent),
//    the phase-table constant, and the function coil_pattern(idx) -> logic [3:0].
//  - Sub-module stepper_channel: one FSM, counters, and phase index, instantiated
//    NUM_CH times in a generate loop. The top holds the prescaler and packs/unpacks buses.
// TESTING (TICK_DIV=4, NUM_CH=2, IDLE_HOLD=0)
//  1. Reset: assert rst mid-move on ch0 (steps=10) -> coil_o=0, busy=0, ready=11
//     asynchronously. After release, phase=0.
//  2. ch0 steps=3, dir=1, period=2 -> patterns 1100, 0110, 0011, 1001. done pulse
//     24 clk (+ prescaler phase) after accept. coil=0000 after done.
//  3. ch1 dir=0, steps=5, period=0 (treated as 1) from phase 0 -> 1100, 1001, 0011,
//     0110, 1100, 1001. Runs concurrently with ch0 and neither channel disturbs the other.
//  4. pause_i high for 40 clk during the 2nd step -> no phase change while paused.
//     Total run length is extended by exactly the paused time, rounded to ticks.
//  5. abort_i on ch0 at remaining=4 with pause_i=1 in the same cycle -> IDLE next cycle,
//     no done. A new command issued with abort held is not accepted (ready=0).
//  6. steps=0 -> done pulse 1 cycle after accept, busy never set. With
//     STEPPER_HALF_STEP_EN, steps=9 dir=1 -> idx wraps 7->0->1 and ends at 1000->1100.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg: channel states and coil phase tables; STEPPER_HALF_STEP_EN selects the 8-phase half-step table
package stepper_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} ch_state_e;
`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [NPH*4-1:0] PHASE_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000};
`else
  localparam int NPH = 4;
  localparam logic [NPH*4-1:0] PHASE_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
`endif
  localparam int PH_W = $clog2(NPH);
  function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] idx);
    return PHASE_TABLE[idx*4 +: 4];
  endfunction
endpackage

// File: rtl/stepper_seq_ctrl_if.sv
// stepper_seq_ctrl_if: command, control and coil/status bundle of the stepper sequencer
interface stepper_seq_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int PER_W  = 8,
  parameter int STEP_W = 16
);
  logic                     pause_i;
  logic [NUM_CH-1:0]        abort_i;
  logic [NUM_CH-1:0]        cmd_valid_i;
  logic [NUM_CH-1:0]        cmd_ready_o;
  logic [NUM_CH*STEP_W-1:0] cmd_steps_i;
  logic [NUM_CH-1:0]        cmd_dir_i;
  logic [NUM_CH*PER_W-1:0]  cmd_period_i;
  logic [NUM_CH*4-1:0]      coil_o;
  logic [NUM_CH-1:0]        busy_o;
  logic [NUM_CH-1:0]        done_o;
  modport master (
    output pause_i, abort_i, cmd_valid_i, cmd_steps_i, cmd_dir_i, cmd_period_i,
    input  cmd_ready_o, coil_o, busy_o, done_o
  );
  modport slave (
    input  pause_i, abort_i, cmd_valid_i, cmd_steps_i, cmd_dir_i, cmd_period_i,
    output cmd_ready_o, coil_o, busy_o, done_o
  );
endinterface

// File: rtl/stepper_channel.sv
// stepper_channel: one motor channel FSM with period counter, remaining steps and persistent phase index
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int PER_W     = 8,
  parameter int STEP_W    = 16,
  parameter int IDLE_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              pause,
  input  logic              abort,
  input  logic              cmd_valid,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [PER_W-1:0]  cmd_period,
  output logic              cmd_ready,
  output logic [3:0]        coil,
  output logic              busy,
  output logic              done
);
  ch_state_e state, state_nx;
  logic [STEP_W-1:0] rem;
  logic [PER_W-1:0] per, cnt;
  logic [PH_W-1:0] phase;
  logic dir, moved, accept, run_tick, step, last;
  always_comb begin
    cmd_ready = state == IDLE && !abort;
    accept = cmd_valid && cmd_ready;
    run_tick = state != IDLE && !abort && !pause && tick;
    step = run_tick && cnt + PER_W'(1) == per;
    last = step && rem == STEP_W'(1);
    busy = state != IDLE;
    coil = busy || (IDLE_HOLD != 0 && moved) ? coil_pattern(phase) : 4'b0000;
    state_nx = state == IDLE ? (accept && |cmd_steps ? RUN : IDLE)
             : abort || last ? IDLE : pause ? PAUSED : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      per <= '0;
      cnt <= '0;
      phase <= '0;
      dir <= 1'b0;
      moved <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (accept && cmd_steps == '0) || last;
      if (accept && |cmd_steps) moved <= 1'b1;
      if (accept) begin
        rem <= cmd_steps;
        dir <= cmd_dir;
        per <= cmd_period == '0 ? PER_W'(1) : cmd_period;
        cnt <= '0;
      end else if (step) begin
        rem <= rem - STEP_W'(1);
        cnt <= '0;
        phase <= dir ? phase + PH_W'(1) : phase - PH_W'(1);
      end else if (run_tick) begin
        cnt <= cnt + PER_W'(1);
      end
    end
  end
endmodule

// File: rtl/stepper_seq_ctrl.sv
// stepper_seq_ctrl: multi-channel stepper sequencer sharing one tick prescaler and pause; STEPPER_HALF_STEP_EN selects half-step
module stepper_seq_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int TICK_DIV  = 50000,
  parameter int PER_W     = 8,
  parameter int STEP_W    = 16,
  parameter int IDLE_HOLD = 0
) (
  input logic              clk,
  input logic              rst,
  stepper_seq_ctrl_if.slave bus
);
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0] pre;
  logic tick;
  assign tick = pre == DW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + DW'(1);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stepper_channel #(.PER_W(PER_W), .STEP_W(STEP_W), .IDLE_HOLD(IDLE_HOLD)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .pause      (bus.pause_i),
      .abort      (bus.abort_i[c]),
      .cmd_valid  (bus.cmd_valid_i[c]),
      .cmd_steps  (bus.cmd_steps_i[c*STEP_W +: STEP_W]),
      .cmd_dir    (bus.cmd_dir_i[c]),
      .cmd_period (bus.cmd_period_i[c*PER_W +: PER_W]),
      .cmd_ready  (bus.cmd_ready_o[c]),
      .coil       (bus.coil_o[c*4 +: 4]),
      .busy       (bus.busy_o[c]),
      .done       (bus.done_o[c])
    );
  end
endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// tb_stepper_seq_ctrl: directed and random stimulus against a tick-count reference model of the sequencer
module tb_stepper_seq_ctrl;
  localparam int NUM_CH = 2, TICK_DIV = 4, PER_W = 8, STEP_W = 16;
`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
  logic [3:0] tbl [NPH] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
  localparam int NPH = 4;
  logic [3:0] tbl [NPH] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  stepper_seq_ctrl_if #(.NUM_CH(NUM_CH), .PER_W(PER_W), .STEP_W(STEP_W)) bus ();
  stepper_seq_ctrl #(.NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .STEP_W(STEP_W), .IDLE_HOLD(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  int n_checks = 0, n_pass = 0, cyc = 0;
  bit m_busy [NUM_CH], m_done [NUM_CH], m_dir [NUM_CH];
  int m_phase [NUM_CH], m_phase0 [NUM_CH], m_per [NUM_CH], m_steps [NUM_CH], m_eff [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_dir[k] = 0;
      m_phase[k] = 0; m_phase0[k] = 0; m_per[k] = 1; m_steps[k] = 0; m_eff[k] = 0;
    end
  endtask

  // Position is derived from ticks counted since acceptance, not from a step-by-step walk.
  task automatic model_step();
    bit tick;
    tick = (cyc % TICK_DIV) == TICK_DIV - 1;
    cyc++;
    for (int k = 0; k < NUM_CH; k++) begin
      int s, p;
      s = int'(bus.cmd_steps_i[k*STEP_W +: STEP_W]);
      p = int'(bus.cmd_period_i[k*PER_W +: PER_W]);
      m_done[k] = 0;
      if (!m_busy[k]) begin
        if (bus.cmd_valid_i[k] && !bus.abort_i[k]) begin
          m_steps[k] = s; m_per[k] = p == 0 ? 1 : p; m_dir[k] = bus.cmd_dir_i[k];
          m_eff[k] = 0; m_phase0[k] = m_phase[k];
          if (s == 0) m_done[k] = 1;
          else m_busy[k] = 1;
        end
      end else if (bus.abort_i[k]) begin
        m_busy[k] = 0;
      end else if (!bus.pause_i && tick) begin
        m_eff[k]++;
        m_phase[k] = ((m_phase0[k] + (m_dir[k] ? 1 : -1) * (m_eff[k] / m_per[k])) % NPH + NPH) % NPH;
        if (m_eff[k] == m_steps[k] * m_per[k]) begin
          m_busy[k] = 0;
          m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("coil%0d", k), 32'(bus.coil_o[k*4 +: 4]), m_busy[k] ? 32'(tbl[m_phase[k]]) : 32'd0);
      check($sformatf("busy%0d", k), 32'(bus.busy_o[k]), 32'(m_busy[k]));
      check($sformatf("done%0d", k), 32'(bus.done_o[k]), 32'(m_done[k]));
      check($sformatf("ready%0d", k), 32'(bus.cmd_ready_o[k]), 32'(!m_busy[k] && !bus.abort_i[k]));
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cmd(input int k, input int steps, input bit dir, input int per);
    bus.cmd_valid_i[k] = 1'b1;
    bus.cmd_steps_i[k*STEP_W +: STEP_W] = STEP_W'(steps);
    bus.cmd_dir_i[k] = dir;
    bus.cmd_period_i[k*PER_W +: PER_W] = PER_W'(per);
  endtask

  initial begin
    bit reached;
    bus.pause_i = 0; bus.abort_i = '0; bus.cmd_valid_i = '0;
    bus.cmd_steps_i = '0; bus.cmd_dir_i = '0; bus.cmd_period_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    compare();
    cmd(0, 10, 1, 1);
    clk_cycle();
    bus.cmd_valid_i = '0;
    repeat (9) clk_cycle();
    #2 rst = 1;
    #1;
    check("rst_coil", 32'(bus.coil_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready_o), 32'd3);
    @(negedge clk);
    rst = 0;
    model_reset();
    compare();
    cmd(0, 3, 1, 2);
    cmd(1, 5, 0, 0);
    clk_cycle();
    bus.cmd_valid_i = '0;
    repeat (40) clk_cycle();
    cmd(0, 4, 1, 2);
    clk_cycle();
    bus.cmd_valid_i = '0;
    for (int i = 0; i < 200 && m_eff[0] < 3; i++) clk_cycle();
    check("pause_setup", 32'(m_eff[0]), 32'd3);
    bus.pause_i = 1;
    repeat (40) clk_cycle();
    bus.pause_i = 0;
    repeat (40) clk_cycle();
    cmd(0, 8, 1, 1);
    clk_cycle();
    bus.cmd_valid_i = '0;
    reached = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_busy[0] && m_steps[0] - m_eff[0] / m_per[0] == 4) begin
        reached = 1;
        break;
      end
      clk_cycle();
    end
    check("abort_setup", 32'(reached), 32'd1);
    bus.abort_i[0] = 1; bus.pause_i = 1;
    clk_cycle();
    bus.pause_i = 0;
    cmd(0, 3, 1, 1);
    clk_cycle();
    check("abort_block", 32'(bus.busy_o[0]), 32'd0);
    bus.cmd_valid_i = '0; bus.abort_i = '0;
    repeat (4) clk_cycle();
    cmd(1, 0, 1, 3);
    clk_cycle();
    bus.cmd_valid_i = '0;
    repeat (3) clk_cycle();
`ifdef STEPPER_HALF_STEP_EN
    cmd(0, 9, 1, 1);
    clk_cycle();
    bus.cmd_valid_i = '0;
    repeat (50) clk_cycle();
`endif
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) bus.pause_i = ~bus.pause_i;
      for (int k = 0; k < NUM_CH; k++) begin
        bus.abort_i[k] = $urandom_range(0, 59) == 0;
        if ($urandom_range(0, 3) == 0) cmd(k, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        else bus.cmd_valid_i[k] = 1'b0;
      end
      clk_cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
